// File: rtl/blake_msg_sched.sv
// BLAKE-512 message scheduler: loads the ten-word header into msg_out, then steps counter_idx through every round/step slot.
// Optional BLAKE_MSG_BSWAP_EN: byte-reverses each header word before it is stored.
module blake_msg_sched #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         step_en,
    input  logic         abort,
    output logic [639:0] msg_out,
    output logic [5:0]   counter_idx,
    output logic         busy,
    output logic         step_first,
    output logic         step_last,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(4 * NUM_ROUNDS - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_wcnt;
    logic [3:0]     w_wcnt_nxt;
    logic [5:0]     r_cnt;
    logic [5:0]     w_cnt_nxt;
    logic           w_wr_en;
    logic [63:0]    w_word;
    logic [639:0]   r_msg;

    function automatic logic [63:0] byte_rev(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[63-8*i -: 8];
        end
        return r;
    endfunction

`ifdef BLAKE_MSG_BSWAP_EN
    assign w_word = byte_rev(in_data);
`else
    assign w_word = in_data;
`endif

    // Next-state, word-count and step-counter logic; abort overrides any transfer or step.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        if (abort) begin
            w_state_nxt = ST_LOAD;
            w_wcnt_nxt  = 4'd0;
            w_cnt_nxt   = 6'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        w_wr_en = 1'b1;
                        if (r_wcnt == 4'd9) begin
                            w_state_nxt = ST_RUN;
                            w_wcnt_nxt  = 4'd0;
                            w_cnt_nxt   = 6'd0;
                        end else begin
                            w_wcnt_nxt = r_wcnt + 4'd1;
                        end
                    end else begin
                        w_wr_en = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (step_en) begin
                        if (r_cnt == LAST_IDX) begin
                            w_state_nxt = ST_DONE;
                            w_cnt_nxt   = 6'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 6'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_LOAD;
                end
                default: begin
                    w_state_nxt = ST_LOAD;
                    w_wcnt_nxt  = 4'd0;
                    w_cnt_nxt   = 6'd0;
                end
            endcase
        end
    end

    // State, counters and header storage; only accepted words touch msg storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_wcnt  <= 4'd0;
            r_cnt   <= 6'd0;
            r_msg   <= 640'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_cnt   <= w_cnt_nxt;
            for (int k = 0; k < 10; k++) begin
                if (w_wr_en && (r_wcnt == 4'(k))) begin
                    r_msg[639-64*k -: 64] <= w_word;
                end
            end
        end
    end

    // Status outputs decode only registered state, so in_ready never depends on in_valid.
    assign in_ready    = (r_state == ST_LOAD);
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign step_first  = (r_state == ST_RUN) && (r_cnt == 6'd0);
    assign step_last   = (r_state == ST_RUN) && (r_cnt == LAST_IDX);
    assign msg_out     = r_msg;
    assign counter_idx = r_cnt;

endmodule

// File: tb/tb_blake_msg_sched.sv
// Self-checking bench for blake_msg_sched against a word-list / step-count reference model.
module tb_blake_msg_sched;

    localparam int STEPS = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         step_en;
    logic         abort;
    logic [639:0] msg_out;
    logic [5:0]   counter_idx;
    logic         busy;
    logic         step_first;
    logic         step_last;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] model_words [10];
    logic [63:0] stim [10];

    blake_msg_sched #(.NUM_ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .step_en(step_en), .abort(abort), .msg_out(msg_out),
        .counter_idx(counter_idx), .busy(busy), .step_first(step_first),
        .step_last(step_last), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] stored(input logic [63:0] w);
`ifdef BLAKE_MSG_BSWAP_EN
        return {<<8{w}};
`else
        return w;
`endif
    endfunction

    // Word 0 ends up in the top 64 bits after shifting all ten words in.
    function automatic logic [639:0] model_msg();
        logic [639:0] m;
        m = '0;
        for (int k = 0; k < 10; k++) m = {m[575:0], model_words[k]};
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; step_en = 1'b0; in_data = 64'd0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) model_words[k] = 64'd0;
    endtask

    task automatic load_block(input bit gapped);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL load_ready word %0d: in_ready=%b busy=%b want 1/0", i, in_ready, busy);
            else n_pass++;
            in_valid = 1'b1;
            in_data  = stim[i];
            tick();
            model_words[i] = stored(stim[i]);
            if (gapped && i != 9) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                tick();
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL run_entry: in_ready=%b busy=%b want 0/1", in_ready, busy);
        else n_pass++;
        n_checks++;
        if (counter_idx !== 6'd0 || step_first !== 1'b1 || step_last !== 1'b0)
            $display("FAIL run_entry_idx: idx=%0d first=%b last=%b want 0/1/0", counter_idx, step_first, step_last);
        else n_pass++;
        n_checks++;
        if (msg_out !== model_msg()) $display("FAIL load_msg: got %h want %h", msg_out, model_msg());
        else n_pass++;
    endtask

    // mode 0: step_en always 1; 1: toggles starting at 0; 2: random
    task automatic run_block(input int mode, input int exp_cycles);
        int exp_idx;
        int cyc;
        logic [639:0] held;
        exp_idx = 0;
        cyc = 0;
        held = model_msg();
        while (exp_idx < STEPS && cyc < 1000) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || counter_idx !== 6'(exp_idx))
                $display("FAIL run_idx cyc %0d: busy=%b done=%b idx=%0d want 1/0/%0d", cyc, busy, done, counter_idx, exp_idx);
            else n_pass++;
            n_checks++;
            if (step_first !== (exp_idx == 0) || step_last !== (exp_idx == STEPS - 1))
                $display("FAIL run_flags idx %0d: first=%b last=%b", exp_idx, step_first, step_last);
            else n_pass++;
            n_checks++;
            if (msg_out !== held) $display("FAIL run_msg_stable cyc %0d: got %h want %h", cyc, msg_out, held);
            else n_pass++;
            case (mode)
                0: step_en = 1'b1;
                1: step_en = (cyc % 2) == 1;
                default: step_en = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
            if (step_en) exp_idx++;
        end
        step_en = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || counter_idx !== 6'd0)
            $display("FAIL done_pulse: done=%b busy=%b in_ready=%b idx=%0d want 1/0/0/0", done, busy, in_ready, counter_idx);
        else n_pass++;
        n_checks++;
        if (msg_out !== held) $display("FAIL done_msg: got %h want %h", msg_out, held);
        else n_pass++;
        if (exp_cycles >= 0) begin
            n_checks++;
            if (cyc !== exp_cycles) $display("FAIL done_latency: got %0d want %0d", cyc, exp_cycles);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL after_done: done=%b in_ready=%b busy=%b want 0/1/0", done, in_ready, busy);
        else n_pass++;
        n_checks++;
        if (msg_out !== held) $display("FAIL retain_msg: got %h want %h", msg_out, held);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_checks++;
        if (msg_out !== 640'd0 || counter_idx !== 6'd0) $display("FAIL reset_data: msg=%h idx=%0d want 0/0", msg_out, counter_idx);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || step_first !== 1'b0 || step_last !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_ctrl: busy=%b done=%b first=%b last=%b in_ready=%b want 0/0/0/0/1",
                     busy, done, step_first, step_last, in_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) stim[i] = 64'(i);
        load_block(1'b0);
        n_checks++;
        if (msg_out[639:576] !== stored(64'd0) || msg_out[63:0] !== stored(64'd9))
            $display("FAIL b2b_slots: w0=%h w9=%h want %h/%h", msg_out[639:576], msg_out[63:0], stored(64'd0), stored(64'd9));
        else n_pass++;
        run_block(0, STEPS);
    endtask

    task automatic test_gapped_toggle();
        for (int i = 0; i < 10; i++) stim[i] = {$urandom, $urandom};
        load_block(1'b1);
        run_block(1, 2 * STEPS);
    endtask

    task automatic test_random_run();
        for (int i = 0; i < 10; i++) stim[i] = {$urandom, $urandom};
        load_block(1'($urandom_range(0, 1)));
        run_block(2, -1);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 10; i++) stim[i] = {$urandom, $urandom};
        load_block(1'b0);
        for (int k = 0; k < 20; k++) begin
            step_en = 1'b1;
            tick();
        end
        n_checks++;
        if (counter_idx !== 6'd20) $display("FAIL abort_pre_idx: got %0d want 20", counter_idx);
        else n_pass++;
        abort = 1'b1;
        step_en = 1'b1;
        tick();
        abort = 1'b0;
        step_en = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || counter_idx !== 6'd0 || done !== 1'b0)
            $display("FAIL abort_run: in_ready=%b busy=%b idx=%0d done=%b want 1/0/0/0", in_ready, busy, counter_idx, done);
        else n_pass++;
        n_checks++;
        if (msg_out !== model_msg()) $display("FAIL abort_msg: got %h want %h", msg_out, model_msg());
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", done);
        else n_pass++;
        // Partial load, then abort alongside a valid word: that word must not land.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = {$urandom, $urandom};
            model_words[i] = stored(in_data);
            tick();
        end
        abort = 1'b1;
        in_data = {$urandom, $urandom};
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (msg_out !== model_msg() || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL abort_load: msg=%h in_ready=%b busy=%b want %h/1/0", msg_out, in_ready, busy, model_msg());
        else n_pass++;
        for (int i = 0; i < 10; i++) stim[i] = {$urandom, $urandom};
        load_block(1'b1);
        run_block(0, STEPS);
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 10; i++) stim[i] = {$urandom, $urandom};
        load_block(1'b0);
        for (int k = 0; k < 10; k++) begin
            step_en = 1'b1;
            tick();
        end
        rst = 1'b1;
        abort = 1'b1;
        tick();
        rst = 1'b0;
        abort = 1'b0;
        step_en = 1'b0;
        for (int k = 0; k < 10; k++) model_words[k] = 64'd0;
        n_checks++;
        if (msg_out !== 640'd0 || counter_idx !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_mid_run: msg=%h idx=%0d busy=%b done=%b in_ready=%b", msg_out, counter_idx, busy, done, in_ready);
        else n_pass++;
    endtask

    task automatic test_bswap();
        logic [63:0] want;
`ifdef BLAKE_MSG_BSWAP_EN
        want = 64'hEFCDAB8967452301;
`else
        want = 64'h0123456789ABCDEF;
`endif
        do_reset();
        stim[0] = 64'h0123456789ABCDEF;
        for (int i = 1; i < 10; i++) stim[i] = {$urandom, $urandom};
        load_block(1'b0);
        n_checks++;
        if (msg_out[639:576] !== want) $display("FAIL bswap_word0: got %h want %h", msg_out[639:576], want);
        else n_pass++;
        run_block(2, -1);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped_toggle();
        test_random_run();
        test_abort();
        test_reset_mid_run();
        test_bswap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
